// File: rtl/spi_ctrl_fsm.sv
// Sequences 1..256 fixed-length SPI words from a control-register send command; clear aborts and resets the path.
// Latency: o_send one cycle after the send edge; each word costs XFER_CYCLES+2 cycles, plus one write-back cycle per run.
// Backpressure: none; send edges arriving while a run is active are dropped, and clear preempts everything.
module spi_ctrl_fsm #(
    parameter int XFER_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_data_control,
    output logic [7:0]  transac,
    output logic        o_send,
    output logic        o_clear,
    output logic        eneable_SPI,
    output logic        WR2D,
    output logic        WR2C
);
    localparam int CW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XFER_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_START, S_BUSY, S_WRITE, S_WBACK
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    transac_q, transac_d;
    logic [7:0]    n_end_q, n_end_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          send_q;
    logic          send_rise, clr;
    logic          o_send_q, o_send_d, o_clear_q, o_clear_d;
    logic          en_q, en_d, wr2d_q, wr2d_d, wr2c_q, wr2c_d;
    logic          unused_ctrl_bits;

    assign unused_ctrl_bits = &{1'b0, i_data_control[31:12], i_data_control[3:2]};
    assign send_rise = i_data_control[0] & ~send_q;
    assign clr       = i_data_control[1];

    always_comb begin
        state_d   = state_q;
        transac_d = transac_q;
        n_end_d   = n_end_q;
        cnt_d     = cnt_q;
        // Clear wins over everything except an ongoing CLEAR, so a held clear alternates CLEAR/IDLE.
        if (clr && state_q != S_CLEAR) begin
            state_d   = S_CLEAR;
            transac_d = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (send_rise) begin
                        state_d   = S_START;
                        transac_d = 8'd0;
                        n_end_d   = i_data_control[11:4];
                    end
                end
                S_CLEAR: state_d = S_IDLE;
                S_START: begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                end
                S_BUSY: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (transac_q == n_end_q) begin
                        state_d = S_WBACK;
                    end else begin
                        state_d   = S_START;
                        transac_d = transac_q + 8'd1;
                    end
                end
                S_WBACK: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with the state itself.
    always_comb begin
        o_send_d  = (state_d == S_START);
        o_clear_d = (state_d == S_CLEAR);
        en_d      = (state_d == S_START) || (state_d == S_BUSY);
        wr2d_d    = (state_d == S_WRITE);
        wr2c_d    = (state_d == S_CLEAR) || (state_d == S_WBACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            transac_q <= 8'd0;
            n_end_q   <= 8'd0;
            cnt_q     <= '0;
            send_q    <= 1'b0;
            o_send_q  <= 1'b0;
            o_clear_q <= 1'b0;
            en_q      <= 1'b0;
            wr2d_q    <= 1'b0;
            wr2c_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            transac_q <= transac_d;
            n_end_q   <= n_end_d;
            cnt_q     <= cnt_d;
            send_q    <= i_data_control[0];
            o_send_q  <= o_send_d;
            o_clear_q <= o_clear_d;
            en_q      <= en_d;
            wr2d_q    <= wr2d_d;
            wr2c_q    <= wr2c_d;
        end
    end

    assign transac     = transac_q;
    assign o_send      = o_send_q;
    assign o_clear     = o_clear_q;
    assign eneable_SPI = en_q;
    assign WR2D        = wr2d_q;
    assign WR2C        = wr2c_q;
endmodule

// File: tb/tb_spi_ctrl_fsm.sv
// Bench for spi_ctrl_fsm: directed and random command sequences against a trace-schedule model.
module tb_spi_ctrl_fsm;
    localparam int XFER = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = 32'd0;
    logic [7:0]  transac;
    logic        o_send, o_clear, eneable_SPI, WR2D, WR2C;

    always #5 clk = ~clk;

    spi_ctrl_fsm #(.XFER_CYCLES(XFER)) dut (
        .clk(clk), .rst(rst), .i_data_control(din), .transac(transac),
        .o_send(o_send), .o_clear(o_clear), .eneable_SPI(eneable_SPI),
        .WR2D(WR2D), .WR2C(WR2C)
    );

    // o = {o_send, o_clear, eneable_SPI, WR2D, WR2C}
    typedef struct packed {
        logic       idle;
        logic       is_clr;
        logic [4:0] o;
        logic [7:0] tr;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic prev0 = 1'b0;
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t ent(logic idle, logic isc, logic [4:0] o, logic [7:0] tr);
        exp_t e;
        e.idle = idle; e.is_clr = isc; e.o = o; e.tr = tr;
        return e;
    endfunction

    function automatic logic [31:0] mk(logic s, logic c, logic [7:0] n);
        logic [31:0] r;
        r = $urandom;
        r[0] = s; r[1] = c; r[11:4] = n;
        return r;
    endfunction

    // Expected outputs are a schedule of future cycles: a send edge in idle enqueues the whole run.
    task automatic model_edge();
        logic rise;
        int   n;
        if (rst) begin
            q.delete();
            prev0 = 1'b0;
            cur = ent(1'b1, 1'b0, 5'b0, 8'd0);
        end else begin
            rise  = din[0] & ~prev0;
            prev0 = din[0];
            if (din[1] && !cur.is_clr) begin
                q.delete();
                q.push_back(ent(1'b0, 1'b1, 5'b01001, 8'd0));
            end else if (cur.idle && rise) begin
                n = int'(din[11:4]);
                for (int w = 0; w <= n; w++) begin
                    q.push_back(ent(1'b0, 1'b0, 5'b10100, 8'(w)));
                    for (int k = 0; k < XFER; k++) q.push_back(ent(1'b0, 1'b0, 5'b00100, 8'(w)));
                    q.push_back(ent(1'b0, 1'b0, 5'b00010, 8'(w)));
                end
                q.push_back(ent(1'b0, 1'b0, 5'b00001, 8'(n)));
            end
            if (q.size() > 0) cur = q.pop_front();
            else              cur = ent(1'b1, 1'b0, 5'b0, cur.tr);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] d, input string tag);
        rst = r;
        din = d;
        @(posedge clk);
        model_edge();
        #1;
        total++;
        assert ({o_send, o_clear, eneable_SPI, WR2D, WR2C, transac} === {cur.o, cur.tr})
        else begin
            bad++;
            $error("FAIL %s: got outs=%b transac=%0d, want outs=%b transac=%0d", tag,
                   {o_send, o_clear, eneable_SPI, WR2D, WR2C}, transac, cur.o, cur.tr);
        end
    endtask

    initial begin
        cur = ent(1'b1, 1'b0, 5'b0, 8'd0);

        step(1'b1, $urandom, "reset0");
        step(1'b1, $urandom, "reset1");
        for (int i = 0; i < 3; i++) step(1'b0, mk(1'b0, 1'b0, 8'($urandom)), "idle");

        // single word, send held through the run and beyond
        for (int i = 0; i < 14; i++) step(1'b0, mk(1'b1, 1'b0, 8'd0), "single");
        step(1'b0, mk(1'b0, 1'b0, 8'd0), "single_drop");

        // three words with [11:4] wiggling after the start edge
        step(1'b0, mk(1'b1, 1'b0, 8'd2), "multi_start");
        for (int i = 0; i < 32; i++) step(1'b0, mk(1'b1, 1'b0, 8'($urandom)), "multi");

        // held send: one run only, then drop and rise again
        step(1'b0, mk(1'b0, 1'b0, 8'd0), "held_pre");
        for (int i = 0; i < 40; i++) step(1'b0, mk(1'b1, 1'b0, 8'd1), "held");
        step(1'b0, mk(1'b0, 1'b0, 8'd0), "held_drop");
        for (int i = 0; i < 14; i++) step(1'b0, mk(1'b1, 1'b0, 8'd0), "held_rerun");

        // clear with simultaneous send edge, then plain clear
        step(1'b0, mk(1'b0, 1'b0, 8'd0), "clr_pre");
        step(1'b0, mk(1'b1, 1'b1, 8'd3), "clr_send");
        for (int i = 0; i < 3; i++) step(1'b0, mk(1'b1, 1'b0, 8'd3), "clr_after");
        step(1'b0, mk(1'b0, 1'b1, 8'd0), "clr_plain");
        step(1'b0, mk(1'b0, 1'b0, 8'd0), "clr_idle");

        // abort in BUSY cycle 3
        step(1'b0, mk(1'b1, 1'b0, 8'd4), "abort_start");
        for (int i = 0; i < 3; i++) step(1'b0, mk(1'b1, 1'b0, 8'd4), "abort_busy");
        step(1'b0, mk(1'b0, 1'b1, 8'd4), "abort_clr");
        for (int i = 0; i < 4; i++) step(1'b0, mk(1'b0, 1'b0, 8'd0), "abort_idle");

        // reset mid-BUSY, send held across reset restarts a run
        step(1'b0, mk(1'b1, 1'b0, 8'd1), "rst_start");
        for (int i = 0; i < 5; i++) step(1'b0, mk(1'b1, 1'b0, 8'd1), "rst_busy");
        step(1'b1, mk(1'b1, 1'b0, 8'd0), "rst_mid");
        for (int i = 0; i < 12; i++) step(1'b0, mk(1'b1, 1'b0, 8'd0), "rst_held_send");

        // clear held: CLEAR/IDLE alternation
        for (int i = 0; i < 7; i++) step(1'b0, mk(1'b0, 1'b1, 8'd0), "clr_held");
        step(1'b0, mk(1'b0, 1'b0, 8'd0), "clr_held_end");

        // send toggling during a run must not queue a second run
        step(1'b0, mk(1'b1, 1'b0, 8'd1), "toggle_start");
        for (int i = 0; i < 24; i++) step(1'b0, mk(1'(i & 1), 1'b0, 8'd7), "toggle");

        // 256-word run, transac must not wrap
        step(1'b0, mk(1'b0, 1'b0, 8'd0), "max_pre");
        step(1'b0, mk(1'b1, 1'b0, 8'd255), "max_start");
        for (int i = 0; i < 256 * (XFER + 2) + 4; i++) step(1'b0, mk(1'b0, 1'b0, 8'($urandom)), "max");

        // random mix
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 mk(1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0), 8'($urandom_range(0, 6))),
                 "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
